conv_out_writer: RTL and testbench

//  Write-back end of the conv datapath. Accepts the MAC product stream tagged with the

---
 rtl/conv_pkg.sv | 34 +++
 rtl/conv_out_writer_acc_bank.sv | 37 +++
 rtl/conv_out_writer.sv | 169 ++++++++++++++++
 tb/tb_conv_out_writer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared parameters, FSM encoding and ACC_W->OUT_W saturation for the conv write-back path.
`timescale 1ns/1ps
package conv_pkg;

  localparam int PROD_W      = 16;
  localparam int ACC_W       = 24;
  localparam int OUT_W       = 16;
  localparam int NUM_REG     = 16;
  localparam int OUT_CHANNEL = 4;
  localparam int ADDR_W      = 8;
  localparam int IDX_W       = $clog2(NUM_REG);
  localparam int CHAN_W      = $clog2(OUT_CHANNEL);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // In range exactly when all bits above the output sign bit match it.
  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] a);
    logic [ACC_W-OUT_W:0] hi_bits;
    logic [OUT_W-1:0]     res;
    hi_bits = a[ACC_W-1:OUT_W-1];
    if ((&hi_bits) || (~|hi_bits)) begin
      res = a[OUT_W-1:0];
    end else if (a[ACC_W-1]) begin
      res = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, {(OUT_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_out_writer_acc_bank.sv
// NUM_REG x ACC_W accumulator bank: sign-extending accumulate port, clear port, read mux.
`timescale 1ns/1ps
module acc_bank
  import conv_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              acc_en,
  input  logic [IDX_W-1:0]  acc_idx,
  input  logic [PROD_W-1:0] acc_val,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_idx,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [ACC_W-1:0]  rd_data
);

  logic [ACC_W-1:0] acc_q [NUM_REG];
  logic [ACC_W-1:0] ext_s;

  assign ext_s = {{(ACC_W-PROD_W){acc_val[PROD_W-1]}}, acc_val};

  // Accumulation wraps at ACC_W; clear wins if both ever coincide.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REG; i++) begin
        acc_q[i] <= '0;
      end
    end else if (clr_en) begin
      acc_q[clr_idx] <= '0;
    end else if (acc_en) begin
      acc_q[acc_idx] <= acc_q[acc_idx] + ext_s;
    end
  end

  assign rd_data = acc_q[rd_idx];

endmodule

// File: rtl/conv_out_writer.sv
// Write-back end of the conv datapath: accumulates tagged MAC products per neuron,
// then drains the tile into the output-feature-map BRAM one word per cycle.
`timescale 1ns/1ps
module conv_out_writer
  import conv_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic [IDX_W-1:0]  prod_reg_idx,
  input  logic              prod_last,
  input  logic [CHAN_W-1:0] chan_idx,
  input  logic [ADDR_W-1:0] out_base_addr,
  input  logic              flush,
  output logic              out_buf_en,
  output logic              out_buf_we,
  output logic [ADDR_W-1:0] out_buf_addr,
  output logic [OUT_W-1:0]  out_buf_din,
  output logic              cell_ready,
  output logic              busy,
  output logic              err
);

  state_t              state_q, state_d;
  logic [NUM_REG-1:0]  done_q, done_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                err_q, err_d;
  logic                prod_ready_q, prod_ready_d;
  logic                busy_q, busy_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [OUT_W-1:0]    din_q, din_d;
  logic                last_q, last_d;
  logic                cell_q, cell_d;

  logic                beat_s, idx_ok_s, acc_en_s, bad_beat_s, clr_en_s;
  logic [ACC_W-1:0]    rd_data_s;

  if (NUM_REG == (1 << IDX_W)) begin : g_idx_full
    assign idx_ok_s = 1'b1;
  end else begin : g_idx_part
    assign idx_ok_s = (int'(prod_reg_idx) < NUM_REG);
  end

  assign beat_s     = prod_valid & prod_ready_q & (state_q == ST_ACCUM);
  assign acc_en_s   = beat_s & idx_ok_s & ~done_q[prod_reg_idx];
  assign bad_beat_s = beat_s & ~(idx_ok_s & ~done_q[prod_reg_idx]);

  acc_bank u_acc_bank (
    .clock   (clock),
    .reset_n (reset_n),
    .acc_en  (acc_en_s),
    .acc_idx (prod_reg_idx),
    .acc_val (prod_data),
    .clr_en  (clr_en_s),
    .clr_idx (cnt_q),
    .rd_idx  (cnt_q),
    .rd_data (rd_data_s)
  );

  // State and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ACCUM;
      done_q       <= '0;
      cnt_q        <= '0;
      base_q       <= '0;
      err_q        <= 1'b0;
      prod_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      din_q        <= '0;
      last_q       <= 1'b0;
      cell_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      err_q        <= err_d;
      prod_ready_q <= prod_ready_d;
      busy_q       <= busy_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      last_q       <= last_d;
      cell_q       <= cell_d;
    end
  end

  // Next state: flush is only honoured in ACCUM; drain leaves after the last neuron.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: begin
        if (flush || (&done_q)) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == IDX_W'(NUM_REG - 1)) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    done_d       = done_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    err_d        = err_q | bad_beat_s;
    prod_ready_d = (state_d == ST_ACCUM);
    busy_d       = (state_d == ST_DRAIN);
    wr_d         = 1'b0;
    addr_d       = '0;
    din_d        = '0;
    last_d       = 1'b0;
    cell_d       = last_q;
    clr_en_s     = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (acc_en_s && prod_last) begin
          done_d[prod_reg_idx] = 1'b1;
        end else begin
          done_d = done_q;
        end
        if (state_d == ST_DRAIN) begin
          cnt_d  = '0;
          base_d = out_base_addr + ADDR_W'(chan_idx) * ADDR_W'(NUM_REG);
        end else begin
          base_d = base_q;
        end
      end
      ST_DRAIN: begin
        wr_d          = 1'b1;
        addr_d        = base_q + ADDR_W'(cnt_q);
        din_d         = sat(rd_data_s);
        clr_en_s      = 1'b1;
        done_d[cnt_q] = 1'b0;
        cnt_d         = cnt_q + IDX_W'(1);
        last_d        = (state_d == ST_ACCUM);
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign prod_ready   = prod_ready_q;
  assign busy         = busy_q;
  assign err          = err_q;
  assign out_buf_en   = wr_q;
  assign out_buf_we   = wr_q;
  assign out_buf_addr = addr_q;
  assign out_buf_din  = din_q;
  assign cell_ready   = cell_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Directed self-checking bench for conv_out_writer with hand-computed tile contents.
`timescale 1ns/1ps
module tb_conv_out_writer;

  logic        clock;
  logic        reset_n;
  logic        prod_valid;
  logic        prod_ready;
  logic [15:0] prod_data;
  logic [3:0]  prod_reg_idx;
  logic        prod_last;
  logic [1:0]  chan_idx;
  logic [7:0]  out_base_addr;
  logic        flush;
  logic        out_buf_en;
  logic        out_buf_we;
  logic [7:0]  out_buf_addr;
  logic [15:0] out_buf_din;
  logic        cell_ready;
  logic        busy;
  logic        err;

  int          n_checks;
  int          n_errors;
  logic [15:0] exp_din [16];

  conv_out_writer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .prod_valid    (prod_valid),
    .prod_ready    (prod_ready),
    .prod_data     (prod_data),
    .prod_reg_idx  (prod_reg_idx),
    .prod_last     (prod_last),
    .chan_idx      (chan_idx),
    .out_base_addr (out_base_addr),
    .flush         (flush),
    .out_buf_en    (out_buf_en),
    .out_buf_we    (out_buf_we),
    .out_buf_addr  (out_buf_addr),
    .out_buf_din   (out_buf_din),
    .cell_ready    (cell_ready),
    .busy          (busy),
    .err           (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_exp();
    for (int i = 0; i < 16; i++) exp_din[i] = 16'h0000;
  endtask

  // Called at a negedge; holds the beat until accepted, returns at the next negedge.
  task automatic beat(input logic [3:0] idx, input logic [15:0] d, input logic last);
    int t;
    prod_valid   = 1'b1;
    prod_reg_idx = idx;
    prod_data    = d;
    prod_last    = last;
    t = 0;
    while (!prod_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!prod_ready) chk("beat_timeout", 32'd0, 32'd1);
    @(negedge clock);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic do_flush(input logic [1:0] c, input logic [7:0] b);
    chan_idx      = c;
    out_base_addr = b;
    flush         = 1'b1;
    @(negedge clock);
    flush = 1'b0;
  endtask

  task automatic collect_drain(input string tag, input logic [7:0] base, output int lat);
    logic [7:0] ea;
    lat = 0;
    while (!out_buf_we && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    if (!out_buf_we) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int n = 0; n < 16; n++) begin
      ea = base + 8'(n);
      chk({tag, "_we"}, {30'd0, out_buf_en, out_buf_we}, 32'd3);
      chk({tag, "_addr"}, {24'd0, out_buf_addr}, {24'd0, ea});
      chk({tag, "_din"}, {16'd0, out_buf_din}, {16'd0, exp_din[n]});
      @(negedge clock);
    end
    chk({tag, "_cell"}, {31'd0, cell_ready}, 32'd1);
    chk({tag, "_we_end"}, {31'd0, out_buf_we}, 32'd0);
    @(negedge clock);
    chk({tag, "_cell_pulse"}, {31'd0, cell_ready}, 32'd0);
  endtask

  initial begin
    int lat;
    int lows;
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    prod_valid    = 1'b0;
    prod_data     = 16'h0000;
    prod_reg_idx  = 4'h0;
    prod_last     = 1'b0;
    chan_idx      = 2'd0;
    out_base_addr = 8'h00;
    flush         = 1'b0;
    repeat (3) @(negedge clock);

    // 1: reset values
    chk("rst_we", {31'd0, out_buf_we}, 32'd0);
    chk("rst_cell", {31'd0, cell_ready}, 32'd0);
    chk("rst_ready", {31'd0, prod_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 2: full tile, 9 beats of n per neuron, chan 1 base 0
    chan_idx      = 2'd1;
    out_base_addr = 8'h00;
    clr_exp();
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 9; k++) beat(4'(n), 16'(n), (k == 8));
      exp_din[n] = 16'(9 * n);
    end
    chk("t2_busy_pre", {31'd0, busy}, 32'd0);
    collect_drain("t2", 8'h10, lat);
    chk("t2_latency", lat, 32'd2);
    chk("t2_ready_after", {31'd0, prod_ready}, 32'd1);

    // 3: saturation both directions, chan 2 base 0x05
    clr_exp();
    for (int k = 0; k < 3; k++) beat(4'd0, 16'h7FFF, (k == 2));
    for (int k = 0; k < 3; k++) beat(4'd1, 16'h8000, (k == 2));
    exp_din[0] = 16'h7FFF;
    exp_din[1] = 16'h8000;
    do_flush(2'd2, 8'h05);
    collect_drain("t3", 8'h25, lat);
    chk("t3_flush_latency", lat, 32'd1);

    // 4: beat on flush edge is kept; held beat waits out the drain exactly once
    clr_exp();
    beat(4'd1, 16'hFFFE, 1'b1);
    exp_din[1] = 16'hFFFE;
    exp_din[4] = 16'h0006;
    chan_idx      = 2'd0;
    out_base_addr = 8'h60;
    flush         = 1'b1;
    prod_valid    = 1'b1;
    prod_reg_idx  = 4'd4;
    prod_data     = 16'h0006;
    prod_last     = 1'b0;
    @(negedge clock);
    flush        = 1'b0;
    prod_reg_idx = 4'd5;
    prod_data    = 16'h0009;
    fork
      begin
        lows = 0;
        while (!prod_ready && lows < 40) begin
          lows++;
          @(negedge clock);
        end
        @(negedge clock);
        prod_valid = 1'b0;
      end
      collect_drain("t4a", 8'h60, lat);
    join
    chk("t4_ready_low_cycles", lows, 32'd16);
    clr_exp();
    exp_din[5] = 16'h0009;
    do_flush(2'd0, 8'h70);
    collect_drain("t4b", 8'h70, lat);

    // 5: flush with neurons 0..3 done, base wraps; then bank must be empty
    clr_exp();
    for (int n = 0; n < 4; n++) begin
      beat(4'(n), 16'h0005, 1'b1);
      exp_din[n] = 16'h0005;
    end
    do_flush(2'd3, 8'hF8);
    collect_drain("t5a", 8'h28, lat);
    clr_exp();
    do_flush(2'd0, 8'hF8);
    collect_drain("t5b", 8'hF8, lat);

    // 6: extra beat to a done neuron, then reset mid-drain
    clr_exp();
    beat(4'd2, 16'h0004, 1'b0);
    beat(4'd2, 16'h0004, 1'b1);
    chk("t6_err_before", {31'd0, err}, 32'd0);
    beat(4'd2, 16'h0064, 1'b0);
    chk("t6_err_set", {31'd0, err}, 32'd1);
    exp_din[2] = 16'h0008;
    do_flush(2'd1, 8'h40);
    collect_drain("t6a", 8'h50, lat);
    chk("t6_err_sticky", {31'd0, err}, 32'd1);

    beat(4'd7, 16'h000B, 1'b1);
    do_flush(2'd3, 8'h80);
    lat = 0;
    while (!out_buf_we && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    repeat (7) @(negedge clock);
    chk("t6_write7_addr", {24'd0, out_buf_addr}, 32'h000000B7);
    chk("t6_write7_din", {16'd0, out_buf_din}, 32'h0000000B);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_we", {31'd0, out_buf_we}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_ready", {31'd0, prod_ready}, 32'd1);
    chk("t6_rst_err", {31'd0, err}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    clr_exp();
    beat(4'd0, 16'h0002, 1'b1);
    exp_din[0] = 16'h0002;
    do_flush(2'd0, 8'h00);
    collect_drain("t6b", 8'h00, lat);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
